fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 87 ++++++++
 tb/tb_fifo_wr_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_BURST = 4;

  typedef enum logic {
    ARB   = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last+1.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   win,
  output logic            any
);

  int unsigned idx;
  logic        found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last) + k) % NREQ;
      if (!found && req[IW'(idx)]) begin
        win   = IW'(idx);
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters,
// with bounded bursts per grant and a running write counter.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NREQ  = DEF_NREQ,
  parameter  int unsigned DW    = DEF_DW,
  parameter  int unsigned BURST = DEF_BURST,
  localparam int unsigned IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [DW-1:0]    fifo_din,
  output logic             gnt_valid,
  output logic [IW-1:0]    gnt_id,
  output logic [15:0]      beat_total
);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] last_gnt;
  logic [IW-1:0] pick_id;
  logic          pick_any;
  logic [3:0]    beat_cnt;
  logic          sel_valid;
  logic          wr;
  logic          burst_end;
  logic [DW-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DW +: DW];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req  (req_valid),
    .last (last_gnt),
    .win  (pick_id),
    .any  (pick_any)
  );

  always_comb begin
    gnt_valid         = (state == GRANT);
    sel_valid         = req_valid[gnt_id];
    req_ready         = '0;
    req_ready[gnt_id] = gnt_valid && !fifo_full;
    wr                = sel_valid && gnt_valid && !fifo_full;
    // reset blanks the data path too, since gnt_id alone would still select requester 0
    fifo_din          = rst ? data_arr[gnt_id] : '0;
    burst_end         = wr && (beat_cnt == 4'(BURST - 1));
    state_nxt         = state;
    case (state)
      ARB:     if (pick_any) state_nxt = GRANT;
      GRANT:   if (burst_end || (!sel_valid && !fifo_full)) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  assign fifo_wr_en = wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB;
      gnt_id     <= '0;
      last_gnt   <= IW'(NREQ - 1);
      beat_cnt   <= '0;
      beat_total <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB && pick_any) begin
        gnt_id   <= pick_id;
        beat_cnt <= '0;
      end else if (wr) begin
        beat_cnt <= beat_cnt + 4'd1;
      end
      if (wr) beat_total <= beat_total + 16'd1;
      if (state == GRANT && state_nxt == ARB) last_gnt <= gnt_id;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector table plus hand-written corner sequences.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic        gnt_valid;
  logic [1:0]  gnt_id;
  logic [15:0] beat_total;

  logic        rst_b;
  logic [3:0]  b_valid;
  logic [31:0] b_data;
  logic [3:0]  b_ready;
  logic        b_wr;
  logic [7:0]  b_din;
  logic        b_gv;
  logic [1:0]  b_gid;
  logic [15:0] b_total;

  int n_chk;
  int n_fail;

  fifo_wr_arbiter #(.NREQ(4), .DW(8), .BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id),
    .beat_total (beat_total)
  );

  fifo_wr_arbiter #(.NREQ(4), .DW(8), .BURST(15)) dut_wrap (
    .clk        (clk),
    .rst        (rst_b),
    .req_valid  (b_valid),
    .req_data   (b_data),
    .req_ready  (b_ready),
    .fifo_full  (1'b0),
    .fifo_wr_en (b_wr),
    .fifo_din   (b_din),
    .gnt_valid  (b_gv),
    .gnt_id     (b_gid),
    .beat_total (b_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic        f;
    logic [31:0] d;
    logic [3:0]  r;
    logic        w;
    logic [7:0]  din;
    logic        gv;
    logic [1:0]  gid;
    logic [15:0] tot;
  } vec_t;

  vec_t tab [12];

  function automatic vec_t mk(logic [3:0] v, logic f, logic [31:0] d, logic [3:0] r, logic w,
                              logic [7:0] din, logic gv, logic [1:0] gid, logic [15:0] tot);
    vec_t x;
    x.v = v; x.f = f; x.d = d; x.r = r; x.w = w;
    x.din = din; x.gv = gv; x.gid = gid; x.tot = tot;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] er, input logic ew,
                           input logic [7:0] ed, input logic eg, input logic [1:0] ei,
                           input logic [15:0] et);
    chk({tag, ".ready"},  32'(req_ready),  32'(er));
    chk({tag, ".wr_en"},  32'(fifo_wr_en), 32'(ew));
    chk({tag, ".din"},    32'(fifo_din),   32'(ed));
    chk({tag, ".gv"},     32'(gnt_valid),  32'(eg));
    chk({tag, ".gid"},    32'(gnt_id),     32'(ei));
    chk({tag, ".total"},  32'(beat_total), 32'(et));
  endtask

  // Inputs change just after a rising edge; outputs are compared on the falling edge.
  task automatic drive(input logic [3:0] v, input logic f, input logic [31:0] d);
    req_valid = v;
    fifo_full = f;
    req_data  = d;
    @(negedge clk);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [3:0] v, input logic f, input logic [31:0] d,
                      input logic [3:0] er, input logic ew, input logic [7:0] ed,
                      input logic eg, input logic [1:0] ei, input logic [15:0] et);
    drive(v, f, d);
    check_out(tag, er, ew, ed, eg, ei, et);
    tick();
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 4'hF;
    req_data  = 32'hDEADBEEF;
    fifo_full = 1'b0;
    @(negedge clk);
    check_out({tag, ".rst"}, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 16'd0);
    tick();
    rst       = 1'b1;
    req_valid = 4'h0;
    req_data  = 32'h0;
  endtask

  initial begin
    int unsigned wcnt;
    logic [15:0] mtot;
    logic        egv;
    logic [1:0]  egid;

    n_chk = 0; n_fail = 0;
    rst = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    rst_b = 1'b0; b_valid = '0; b_data = 32'h04030201;

    // Single requester 0, data 0x10..0x17: two bursts of four with one idle cycle between.
    tab[0]  = mk(4'h1, 1'b0, 32'h10, 4'h0, 1'b0, 8'h10, 1'b0, 2'd0, 16'd0);
    tab[1]  = mk(4'h1, 1'b0, 32'h10, 4'h1, 1'b1, 8'h10, 1'b1, 2'd0, 16'd0);
    tab[2]  = mk(4'h1, 1'b0, 32'h11, 4'h1, 1'b1, 8'h11, 1'b1, 2'd0, 16'd1);
    tab[3]  = mk(4'h1, 1'b0, 32'h12, 4'h1, 1'b1, 8'h12, 1'b1, 2'd0, 16'd2);
    tab[4]  = mk(4'h1, 1'b0, 32'h13, 4'h1, 1'b1, 8'h13, 1'b1, 2'd0, 16'd3);
    tab[5]  = mk(4'h1, 1'b0, 32'h14, 4'h0, 1'b0, 8'h14, 1'b0, 2'd0, 16'd4);
    tab[6]  = mk(4'h1, 1'b0, 32'h14, 4'h1, 1'b1, 8'h14, 1'b1, 2'd0, 16'd4);
    tab[7]  = mk(4'h1, 1'b0, 32'h15, 4'h1, 1'b1, 8'h15, 1'b1, 2'd0, 16'd5);
    tab[8]  = mk(4'h1, 1'b0, 32'h16, 4'h1, 1'b1, 8'h16, 1'b1, 2'd0, 16'd6);
    tab[9]  = mk(4'h1, 1'b0, 32'h17, 4'h1, 1'b1, 8'h17, 1'b1, 2'd0, 16'd7);
    tab[10] = mk(4'h0, 1'b0, 32'h00, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 16'd8);
    tab[11] = mk(4'h0, 1'b0, 32'h00, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 16'd8);

    do_reset("single");
    for (int i = 0; i < 12; i++) begin
      step($sformatf("single[%0d]", i), tab[i].v, tab[i].f, tab[i].d, tab[i].r, tab[i].w,
           tab[i].din, tab[i].gv, tab[i].gid, tab[i].tot);
    end

    // All four valid: grants 0,1,2,3,0 with one ARB cycle between bursts of four.
    do_reset("all");
    mtot = 16'd0;
    for (int k = 0; k < 25; k++) begin
      egv  = (k % 5) != 0;
      egid = egv ? 2'((k / 5) % 4) : ((k < 5) ? 2'd0 : 2'(((k / 5) - 1) % 4));
      drive(4'hF, 1'b0, 32'h43424140);
      chk($sformatf("all[%0d].onehot", k), 32'($countones(req_ready) <= 1), 32'd1);
      check_out($sformatf("all[%0d]", k), egv ? (4'h1 << egid) : 4'h0, egv,
                8'h40 + 8'(egid), egv, egid, mtot);
      if (egv) mtot++;
      tick();
    end
    drive(4'h0, 1'b0, 32'h0);
    chk("all.total", 32'(beat_total), 32'd20);
    tick();

    // Requester 2 stalled by fifo_full after two beats; grant held even if valid drops.
    do_reset("stall");
    step("stall[0]", 4'h4, 1'b0, 32'h00A00000, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 16'd0);
    step("stall[1]", 4'h4, 1'b0, 32'h00A00000, 4'h4, 1'b1, 8'hA0, 1'b1, 2'd2, 16'd0);
    step("stall[2]", 4'h4, 1'b0, 32'h00A10000, 4'h4, 1'b1, 8'hA1, 1'b1, 2'd2, 16'd1);
    for (int k = 0; k < 5; k++) begin
      step($sformatf("stall.full[%0d]", k), (k == 2) ? 4'h0 : 4'h4, 1'b1, 32'h00A20000,
           4'h0, 1'b0, 8'hA2, 1'b1, 2'd2, 16'd2);
    end
    step("stall[8]",  4'h4, 1'b0, 32'h00A20000, 4'h4, 1'b1, 8'hA2, 1'b1, 2'd2, 16'd2);
    step("stall[9]",  4'h4, 1'b0, 32'h00A30000, 4'h4, 1'b1, 8'hA3, 1'b1, 2'd2, 16'd3);
    step("stall[10]", 4'h0, 1'b0, 32'h00000000, 4'h0, 1'b0, 8'h00, 1'b0, 2'd2, 16'd4);

    // Requester 1 goes idle after two beats; with 1 and 3 both asking, 3 must win next.
    do_reset("idle");
    step("idle[0]", 4'hA, 1'b0, 32'hC000B000, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 16'd0);
    step("idle[1]", 4'hA, 1'b0, 32'hC000B000, 4'h2, 1'b1, 8'hB0, 1'b1, 2'd1, 16'd0);
    step("idle[2]", 4'hA, 1'b0, 32'hC000B000, 4'h2, 1'b1, 8'hB0, 1'b1, 2'd1, 16'd1);
    step("idle[3]", 4'h8, 1'b0, 32'hC000B000, 4'h2, 1'b0, 8'hB0, 1'b1, 2'd1, 16'd2);
    step("idle[4]", 4'hA, 1'b0, 32'hC000B000, 4'h0, 1'b0, 8'hB0, 1'b0, 2'd1, 16'd2);
    step("idle[5]", 4'hA, 1'b0, 32'hC000B000, 4'h8, 1'b1, 8'hC0, 1'b1, 2'd3, 16'd2);

    // Reset asserted between edges during requester 1's burst.
    do_reset("abort");
    step("abort[0]", 4'h3, 1'b0, 32'h0000B1A1, 4'h0, 1'b0, 8'hA1, 1'b0, 2'd0, 16'd0);
    for (int k = 1; k < 5; k++) begin
      step($sformatf("abort[%0d]", k), 4'h3, 1'b0, 32'h0000B1A1, 4'h1, 1'b1, 8'hA1, 1'b1,
           2'd0, 16'(k - 1));
    end
    step("abort[5]", 4'h3, 1'b0, 32'h0000B1A1, 4'h0, 1'b0, 8'hA1, 1'b0, 2'd0, 16'd4);
    step("abort[6]", 4'h3, 1'b0, 32'h0000B1A1, 4'h2, 1'b1, 8'hB1, 1'b1, 2'd1, 16'd4);
    drive(4'h3, 1'b0, 32'h0000B1A1);
    check_out("abort[7]", 4'h2, 1'b1, 8'hB1, 1'b1, 2'd1, 16'd5);
    #1;
    rst = 1'b0;
    #1;
    check_out("abort.async", 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 16'd0);
    tick();
    tick();
    rst = 1'b1;
    step("abort.r0", 4'h3, 1'b0, 32'h0000B1A1, 4'h0, 1'b0, 8'hA1, 1'b0, 2'd0, 16'd0);
    step("abort.r1", 4'h3, 1'b0, 32'h0000B1A1, 4'h1, 1'b1, 8'hA1, 1'b1, 2'd0, 16'd0);

    // Long all-valid run on a BURST=15 instance: beat_total wraps past 0xFFFF.
    @(posedge clk);
    #1;
    rst_b   = 1'b1;
    b_valid = 4'hF;
    wcnt    = 0;
    for (int c = 0; c < 80000; c++) begin
      @(negedge clk);
      if (b_wr) wcnt++;
      if (wcnt == 70000) break;
    end
    chk("wrap.writes", wcnt, 32'd70000);
    @(posedge clk);
    #1;
    b_valid = 4'h0;
    @(negedge clk);
    chk("wrap.total", 32'(b_total), 32'd4464);
    chk("wrap.idle_wr", 32'(b_wr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
